// File: rtl/pool_window_buffer.sv
// Streaming 4x4 window assembler for the max-pooling stage: buffers four image rows
// and presents each completed non-overlapping window in parallel for one cycle.
//
// state  | meaning
// IDLE   | awaiting in_sof; pixels without in_sof are dropped
// ACTIVE | collecting pixels of a frame in raster order
module pool_window_buffer #(
  parameter int DATA_W = 22,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  localparam int WC_W  = (IMG_W / 4 > 1) ? $clog2(IMG_W / 4) : 1,
  localparam int WR_W  = (IMG_H / 4 > 1) ? $clog2(IMG_H / 4) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 win_valid,
  output logic [16*DATA_W-1:0] win_data,
  output logic [WR_W-1:0]      win_row,
  output logic [WC_W-1:0]      win_col,
  output logic                 frame_done,
  output logic                 sof_err
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int AW    = $clog2(4 * IMG_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    pix_addr;
  logic [AW-1:0]    col_base;
  logic             win_fire;
  logic             last_win;
  logic             sof_err_d;
  logic [16*DATA_W-1:0] win_next;

  // Not reset: every slot is rewritten within a frame before it is read.
  logic [DATA_W-1:0] line_buf [4*IMG_W];

  assign pix_addr = AW'(row_q[1:0]) * AW'(IMG_W) + AW'(col_q);
  assign col_base = AW'(col_q & ~COL_W'(3));

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_en     = 1'b0;
    wr_addr   = pix_addr;
    win_fire  = 1'b0;
    last_win  = 1'b0;
    sof_err_d = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A new sof always restarts at (0,0), abandoning any partial frame.
        wr_en     = 1'b1;
        wr_addr   = '0;
        col_d     = COL_W'(1);
        row_d     = '0;
        state_d   = ACTIVE;
        sof_err_d = (state_q == ACTIVE);
      end else if (state_q == ACTIVE) begin
        wr_en    = 1'b1;
        win_fire = (row_q[1:0] == 2'd3) && (col_q[1:0] == 2'd3);
        if (col_q == COL_W'(IMG_W - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(IMG_H - 1)) begin
            row_d    = '0;
            state_d  = IDLE;
            last_win = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  // The completing pixel bypasses the buffer since its slot is written this same edge.
  always_comb begin
    win_next = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == 3 && c == 3)
          win_next[(4*r+c)*DATA_W +: DATA_W] = in_data;
        else
          win_next[(4*r+c)*DATA_W +: DATA_W] = line_buf[AW'(r * IMG_W) + col_base + AW'(c)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_valid  <= win_fire;
      frame_done <= last_win;
      sof_err    <= sof_err_d;
      if (win_fire) begin
        win_data <= win_next;
        win_row  <= WR_W'(row_q >> 2);
        win_col  <= WC_W'(col_q >> 2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_buf[wr_addr] <= in_data;
  end

endmodule

// File: doc/pool_window_buffer.md
# pool_window_buffer

Streaming window assembler that sits directly upstream of the 4x4 max-pooling stage. It accepts convolution results one signed 22-bit pixel per cycle in raster order and buffers four image rows. Each time a non-overlapping 4x4 window is complete, it presents all 16 values in parallel for one cycle with a strobe that drives the pooling stage's `enable`. It also tracks frame boundaries and reports window coordinates and malformed frames.

## Interface
- `DATA_W`, 22, pixel width, two's complement
- `IMG_W`, 16, image width in pixels; multiple of 4, at least 4
- `IMG_H`, 16, image height in pixels; multiple of 4, at least 4
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  `in_data` is a valid pixel this cycle
- `in_sof`  in  1  start of frame; qualified by `in_valid`; marks pixel (0,0)
- `in_data`  in  DATA_W  pixel value, signed
- `win_valid`  out  1  one-cycle strobe: `win_data` holds a complete window; drives pooling `enable`
- `win_data`  out  16*DATA_W  element k = 4r+c at bits [k*DATA_W +: DATA_W] = pixel (4*win_row+r, 4*win_col+c)
- `win_row`  out  clog2(IMG_H/4) (min 1)  window band index
- `win_col`  out  clog2(IMG_W/4) (min 1)  window column index
- `frame_done`  out  1  one-cycle strobe, coincident with the last window of a frame
- `sof_err`  out  1  one-cycle strobe: `in_sof` arrived while a frame was in progress

## Operation
- States:
  - IDLE: awaiting a frame.
  - ACTIVE: collecting pixels.
- IDLE:
  - `in_valid` with `in_sof` = 0: pixel dropped, no state change.
  - `in_valid` with `in_sof` = 1: pixel stored as (0,0); column counter -> 1, row counter 0; go to ACTIVE.
- ACTIVE:
  - Each `in_valid` pixel is written to line-buffer slot [row mod 4][col].
  - Column counter wraps at IMG_W-1 to 0 and increments the row counter.
  - Row counter wraps at IMG_H-1.
  - Acceptance of pixel (IMG_H-1, IMG_W-1) returns the block to IDLE.
- Cycles with `in_valid` = 0 hold all counters and the buffer; gaps are legal anywhere.
- Window completion: accepting the pixel at row%4 = 3 and col%4 = 3 completes window (row/4, col/4).
  - Next edge: `win_data` is registered from the 15 buffered pixels of that window plus the incoming pixel (bypass; do not re-read the slot being written).
  - `win_row`/`win_col` are registered with the window indices; `win_valid` = 1.
- Last window of the frame (IMG_H/4-1, IMG_W/4-1): `frame_done` = 1 in the same cycle as `win_valid`.
- `in_sof` with `in_valid` while ACTIVE:
  - Partial frame abandoned; no window is emitted for incomplete groups.
  - `sof_err` pulses next cycle.
  - The pixel is taken as the new (0,0); state stays ACTIVE.
- Line buffer is 4*IMG_W entries of DATA_W and is not cleared by reset; contents are don't-care until rewritten. No row is read before it is written within the current frame.
- Data is passed unmodified; no arithmetic on pixel values; sign preserved bit-exactly.

## Timing
- Reset values, all forced asynchronously while `rst_n` = 0:
  - `win_valid`, `frame_done`, `sof_err` = 0
  - `win_data`, `win_row`, `win_col` = 0
  - state = IDLE, counters = 0
- First cycle after `rst_n` rises may accept a pixel.
- Latency: 1 cycle from acceptance of a window's final pixel to `win_valid`.
- `win_valid`, `frame_done`, `sof_err` are single-cycle pulses.
- `win_data`, `win_row`, `win_col` hold their value until the next window.
- Minimum spacing between `win_valid` pulses is 4 cycles. No backpressure; the downstream stage must absorb a window every 4 cycles.
- A window-completing pixel and a frame's final pixel never coincide with a new `in_sof` in the same cycle. If `in_sof` is asserted on such a cycle, `in_sof` wins: no window is emitted and `sof_err` pulses.
- `rst_n` asserted mid-frame: outputs clear immediately, the frame is discarded, and the block returns to IDLE.

## Test plan
- 16x16 ramp (pixel = 16*row+col), `in_sof` on first pixel, continuous `in_valid`:
  - 16 `win_valid` pulses, first 1 cycle after pixel 51.
  - Window (0,0) elements 0,1,...,15 = 0,1,2,3,16,...,51.
  - Window (3,3) element 0 = 204, element 15 = 255, with `frame_done` = 1.
- Same frame with random `in_valid` gaps: identical windows and order. `win_valid` never in two consecutive cycles.
- Negative values (e.g. pixel (0,0) = 22'h200000, pixel (3,3) = -1):
  - Window (0,0) bit-exact in `win_data`.
  - A window of -5 values (22'h3FFFFB) is emitted with sign intact.
- 5 pixels without `in_sof` after reset, then a full frame: first 5 dropped; windows are identical to the ramp case.
- `in_sof` at pixel (5,7) of a frame, then a full ramp frame:
  - `sof_err` pulses once.
  - Windows (0,0),(0,1),(0,2),(0,3) from the aborted frame were already emitted; band 1 of the aborted frame is never emitted.
  - The new frame produces 16 correct windows.
- `rst_n` low for 2 cycles at pixel (3,2), i.e. one pixel before window (0,0) completes:
  - Outputs are 0 during reset and no window is emitted.
  - After reset, the block is in IDLE until the next `in_sof`.
